emif_reset_sequencer: RTL and testbench

EMIF_RESET_SEQUENCER -- requirements
Module: emif_reset_sequencer

---
 rtl/emif_reset_sequencer.sv | 158 +++++++++++++++
 tb/tb_emif_reset_sequencer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/emif_reset_sequencer.sv
// Sequences EMIF soft reset, calibration wait, stability qualification and system
// reset release, with bounded retries and a sticky FAIL state cleared by sw_restart.
module emif_reset_sequencer #(
  parameter int unsigned NUM_CH            = 1,
  parameter int unsigned RESET_HOLD_CYCLES = 16,
  parameter int unsigned TIMEOUT_CYCLES    = 5000000,
  parameter int unsigned STABLE_CYCLES     = 64,
  parameter int unsigned MAX_RETRIES       = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] init_done,
  input  logic [NUM_CH-1:0] cal_success,
  input  logic [NUM_CH-1:0] cal_fail,
  input  logic              sw_restart,
  output logic              emif_reset_n,
  output logic              sys_reset_n,
  output logic [2:0]        state,
  output logic [3:0]        retry_count,
  output logic              fail
);

  localparam int unsigned MAX_HT  = (TIMEOUT_CYCLES > RESET_HOLD_CYCLES) ? TIMEOUT_CYCLES : RESET_HOLD_CYCLES;
  localparam int unsigned MAX_CNT = (MAX_HT > STABLE_CYCLES) ? MAX_HT : STABLE_CYCLES;
  localparam int unsigned CW      = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_EMIF_RST = 3'd1,
    S_WAIT_CAL = 3'd2,
    S_STABLE   = 3'd3,
    S_RUN      = 3'd4,
    S_FAIL     = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   stab_q, stab_d;
  logic [3:0]      retry_q, retry_d;
  logic            emif_d, sys_d, fail_d;
  logic            retry_req;

  logic [NUM_CH-1:0] id_s1, id_s2, cs_s1, cs_s2, cf_s1, cf_s2;
  logic              all_good, any_bad, any_fail;

  // Two-flop synchronizers for the asynchronous calibration status bits
  always_ff @(posedge clk) begin
    if (reset) begin
      id_s1 <= '0; id_s2 <= '0;
      cs_s1 <= '0; cs_s2 <= '0;
      cf_s1 <= '0; cf_s2 <= '0;
    end else begin
      id_s1 <= init_done;   id_s2 <= id_s1;
      cs_s1 <= cal_success; cs_s2 <= cs_s1;
      cf_s1 <= cal_fail;    cf_s2 <= cf_s1;
    end
  end

  assign all_good = &(id_s2 & cs_s2 & ~cf_s2);
  assign any_bad  = |(cf_s2 | ~id_s2);
  assign any_fail = |cf_s2;

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      stab_q       <= '0;
      retry_q      <= '0;
      emif_reset_n <= 1'b0;
      sys_reset_n  <= 1'b0;
      fail         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      stab_q       <= stab_d;
      retry_q      <= retry_d;
      emif_reset_n <= emif_d;
      sys_reset_n  <= sys_d;
      fail         <= fail_d;
    end
  end

  // Next-state logic; the timeout counter is frozen while in STABLE
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stab_d    = stab_q;
    retry_d   = retry_q;
    retry_req = 1'b0;
    case (state_q)
      S_IDLE: begin
        state_d = S_EMIF_RST;
        cnt_d   = '0;
      end
      S_EMIF_RST: begin
        if (cnt_q == CW'(RESET_HOLD_CYCLES - 1)) begin
          state_d = S_WAIT_CAL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT_CAL: begin
        if (all_good) begin
          state_d = S_STABLE;
          stab_d  = '0;
        end else if (any_fail || (cnt_q == CW'(TIMEOUT_CYCLES - 1))) begin
          retry_req = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STABLE: begin
        if (!all_good) begin
          state_d = S_WAIT_CAL;
        end else if (stab_q == CW'(STABLE_CYCLES - 1)) begin
          state_d = S_RUN;
        end else begin
          stab_d = stab_q + CW'(1);
        end
      end
      S_RUN: begin
        if (any_bad) retry_req = 1'b1;
      end
      S_FAIL: state_d = S_FAIL;
      default: state_d = S_IDLE;
    endcase

    if (retry_req) begin
      if (retry_q < 4'(MAX_RETRIES)) begin
        retry_d = retry_q + 4'd1;
        state_d = S_EMIF_RST;
        cnt_d   = '0;
      end else begin
        state_d = S_FAIL;
      end
    end

    if (sw_restart) begin
      state_d = S_IDLE;
      retry_d = '0;
      cnt_d   = '0;
      stab_d  = '0;
    end
  end

  // Output decode from the next state so outputs register alongside the state
  always_comb begin
    emif_d = (state_d == S_WAIT_CAL) || (state_d == S_STABLE) || (state_d == S_RUN);
    sys_d  = (state_d == S_RUN);
    fail_d = (state_d == S_FAIL);
  end

  assign state       = state_q;
  assign retry_count = retry_q;

endmodule

// File: tb/tb_emif_reset_sequencer.sv
// Directed bench for emif_reset_sequencer: per-cycle vector table for reset, nominal
// bring-up and runtime loss, then hand sequences for glitch, cal fail, timeout, restart.
module tb_emif_reset_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] init_done = '0, cal_success = '0, cal_fail = '0;
  logic       sw_restart = 1'b0;
  logic       emif_reset_n, sys_reset_n, fail;
  logic [2:0] state;
  logic [3:0] retry_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  emif_reset_sequencer #(
    .NUM_CH(2), .RESET_HOLD_CYCLES(4), .TIMEOUT_CYCLES(100),
    .STABLE_CYCLES(8), .MAX_RETRIES(2)
  ) dut (
    .clk(clk), .reset(reset), .init_done(init_done), .cal_success(cal_success),
    .cal_fail(cal_fail), .sw_restart(sw_restart), .emif_reset_n(emif_reset_n),
    .sys_reset_n(sys_reset_n), .state(state), .retry_count(retry_count), .fail(fail)
  );

  typedef struct {
    logic       rst;
    logic       sw;
    logic [1:0] id, cs, cf;
    logic [2:0] st;
    logic       emif, sys, fl;
    logic [3:0] rc;
  } vec_t;

  vec_t vecs[27];

  function automatic vec_t mk(logic rst, logic sw, logic [1:0] id, logic [1:0] cs, logic [1:0] cf,
                              logic [2:0] st, logic emif, logic sys, logic fl, logic [3:0] rc);
    vec_t v;
    v.rst = rst; v.sw = sw; v.id = id; v.cs = cs; v.cf = cf;
    v.st = st; v.emif = emif; v.sys = sys; v.fl = fl; v.rc = rc;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string name, input int st, input int emif, input int sys,
                         input int fl, input int rc);
    chk({name, ".state"}, int'(state), st);
    chk({name, ".emif_reset_n"}, int'(emif_reset_n), emif);
    chk({name, ".sys_reset_n"}, int'(sys_reset_n), sys);
    chk({name, ".fail"}, int'(fail), fl);
    chk({name, ".retry_count"}, int'(retry_count), rc);
  endtask

  task automatic wait_state(input logic [2:0] st, input int budget, input string name);
    int n = 0;
    while (state != st && n < budget) begin
      step();
      n++;
    end
    chk({name, ".reached"}, int'(state), int'(st));
  endtask

  initial begin
    int n;
    // Reset, nominal bring-up (release 11 edges after inputs go good), runtime loss on ch0
    vecs[0]  = mk(1, 0, 2'b00, 2'b00, 2'b00, 3'd0, 0, 0, 0, 4'd0);
    vecs[1]  = mk(1, 1, 2'b00, 2'b00, 2'b00, 3'd0, 0, 0, 0, 4'd0);
    vecs[2]  = mk(0, 0, 2'b00, 2'b00, 2'b00, 3'd1, 0, 0, 0, 4'd0);
    vecs[3]  = mk(0, 0, 2'b00, 2'b00, 2'b00, 3'd1, 0, 0, 0, 4'd0);
    vecs[4]  = mk(0, 0, 2'b00, 2'b00, 2'b00, 3'd1, 0, 0, 0, 4'd0);
    vecs[5]  = mk(0, 0, 2'b00, 2'b00, 2'b00, 3'd1, 0, 0, 0, 4'd0);
    vecs[6]  = mk(0, 0, 2'b00, 2'b00, 2'b00, 3'd2, 1, 0, 0, 4'd0);
    vecs[7]  = mk(0, 0, 2'b00, 2'b00, 2'b00, 3'd2, 1, 0, 0, 4'd0);
    vecs[8]  = mk(0, 0, 2'b11, 2'b11, 2'b00, 3'd2, 1, 0, 0, 4'd0);
    vecs[9]  = mk(0, 0, 2'b11, 2'b11, 2'b00, 3'd2, 1, 0, 0, 4'd0);
    for (int i = 10; i <= 17; i++)
      vecs[i] = mk(0, 0, 2'b11, 2'b11, 2'b00, 3'd3, 1, 0, 0, 4'd0);
    vecs[18] = mk(0, 0, 2'b11, 2'b11, 2'b00, 3'd4, 1, 1, 0, 4'd0);
    vecs[19] = mk(0, 0, 2'b10, 2'b11, 2'b00, 3'd4, 1, 1, 0, 4'd0);
    vecs[20] = mk(0, 0, 2'b10, 2'b11, 2'b00, 3'd4, 1, 1, 0, 4'd0);
    vecs[21] = mk(0, 0, 2'b10, 2'b11, 2'b00, 3'd1, 0, 0, 0, 4'd1);
    vecs[22] = mk(0, 0, 2'b10, 2'b11, 2'b00, 3'd1, 0, 0, 0, 4'd1);
    vecs[23] = mk(0, 0, 2'b10, 2'b11, 2'b00, 3'd1, 0, 0, 0, 4'd1);
    vecs[24] = mk(0, 0, 2'b10, 2'b11, 2'b00, 3'd1, 0, 0, 0, 4'd1);
    vecs[25] = mk(0, 0, 2'b10, 2'b11, 2'b00, 3'd2, 1, 0, 0, 4'd1);
    vecs[26] = mk(0, 0, 2'b11, 2'b11, 2'b00, 3'd2, 1, 0, 0, 4'd1);

    for (int i = 0; i < 27; i++) begin
      reset = vecs[i].rst; sw_restart = vecs[i].sw;
      init_done = vecs[i].id; cal_success = vecs[i].cs; cal_fail = vecs[i].cf;
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].emif, vecs[i].sys, vecs[i].fl, vecs[i].rc);
    end

    // Glitch in STABLE: one bad cycle restarts the full 8-cycle qualification
    wait_state(3'd3, 10, "glitch_enter");
    repeat (3) step();
    cal_success = 2'b01;
    step();
    cal_success = 2'b11;
    step();
    chk("glitch.still_stable", int'(state), 3);
    step();
    chk("glitch.back_wait", int'(state), 2);
    step();
    chk("glitch.restable", int'(state), 3);
    repeat (7) step();
    chk("glitch.not_yet_run", int'(state), 3);
    chk("glitch.sys_low", int'(sys_reset_n), 0);
    step();
    chk_all("glitch.run", 4, 1, 1, 0, 1);

    // sw_restart in RUN, then ch1 cal_fail every attempt: retries 1, 2, then FAIL
    sw_restart = 1'b1; cal_success = 2'b00; cal_fail = 2'b10;
    step();
    sw_restart = 1'b0;
    chk_all("swr_run", 0, 0, 0, 0, 0);
    wait_state(3'd2, 10, "cf.wait1");
    wait_state(3'd1, 5, "cf.rst1");
    chk("cf.retry1", int'(retry_count), 1);
    wait_state(3'd2, 10, "cf.wait2");
    wait_state(3'd1, 5, "cf.rst2");
    chk("cf.retry2", int'(retry_count), 2);
    wait_state(3'd2, 10, "cf.wait3");
    wait_state(3'd5, 5, "cf.fail");
    repeat (5) step();
    chk_all("cf.fail_hold", 5, 0, 0, 1, 2);

    // Restart from FAIL with good inputs: nominal release, no retries
    sw_restart = 1'b1; cal_fail = 2'b00; init_done = 2'b11; cal_success = 2'b11;
    step();
    sw_restart = 1'b0;
    chk_all("restart.idle", 0, 0, 0, 0, 0);
    wait_state(3'd4, 40, "restart.run");
    chk_all("restart.run_out", 4, 1, 1, 0, 0);

    // Timeout: inputs idle, three 100-cycle windows separated by 4-cycle resets
    sw_restart = 1'b1; init_done = 2'b00; cal_success = 2'b00;
    step();
    sw_restart = 1'b0;
    for (int w = 0; w < 3; w++) begin
      wait_state(3'd2, 10, $sformatf("to.enter%0d", w));
      n = 0;
      while (state == 3'd2 && n < 200) begin
        n++;
        step();
      end
      chk($sformatf("to.window%0d", w), n, 100);
      if (w < 2) begin
        chk_all($sformatf("to.retry%0d", w), 1, 0, 0, 0, w + 1);
        n = 0;
        while (state == 3'd1 && n < 20) begin
          n++;
          step();
        end
        chk($sformatf("to.emif_low%0d", w), n, 4);
      end else begin
        chk_all("to.fail", 5, 0, 0, 1, 2);
      end
    end

    // Reset asserted in RUN drops sys_reset_n on the next edge
    sw_restart = 1'b1; init_done = 2'b11; cal_success = 2'b11;
    step();
    sw_restart = 1'b0;
    wait_state(3'd4, 40, "rst.run");
    reset = 1'b1;
    step();
    chk_all("rst.in_run", 0, 0, 0, 0, 0);
    reset = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
